// File: rtl/forward_scoreboard.sv
// In-flight register write tracker: yields per-operand forwarding selects or a stall request,
// plus a saturating count of stalled advance cycles.
module forward_scoreboard #(
   parameter int unsigned STAGES = 3,
   parameter int unsigned REGS   = 32,
   parameter int unsigned NSRC   = 2,
   parameter int unsigned RA     = $clog2(REGS),
   parameter int unsigned LW     = $clog2(STAGES + 1),
   parameter int unsigned CW     = 16
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 advance,
   input  logic                 flush,
   input  logic                 issue_wen,
   input  logic [RA-1:0]        issue_wsel,
   input  logic [LW-1:0]        issue_lat,
   input  logic [NSRC-1:0]      src_used,
   input  logic [NSRC*RA-1:0]   src_sel,
   output logic [NSRC*LW-1:0]   fwd_sel,
   output logic                 stall,
   output logic [CW-1:0]        stall_cnt
);

   // Entry k (1..STAGES) is stored at index k-1.
   logic [STAGES-1:0] valid_q, valid_d;
   logic [RA-1:0]     wsel_q [STAGES];
   logic [RA-1:0]     wsel_d [STAGES];
   logic [LW-1:0]     lat_q  [STAGES];
   logic [LW-1:0]     lat_d  [STAGES];
   logic [CW-1:0]     cnt_q, cnt_d;

   logic [LW-1:0]     lat_clamped;
   logic              load_ok;

   // Operand lookup: the youngest matching entry decides between forwarding and stalling.
   always_comb begin
      logic [RA-1:0] src;
      logic          hit;
      fwd_sel = '0;
      stall   = 1'b0;
      for (int i = 0; i < int'(NSRC); i++) begin
         src = src_sel[i*RA +: RA];
         hit = 1'b0;
         if (src_used[i] && (src != '0)) begin
            for (int j = 0; j < int'(STAGES); j++) begin
               if (!hit && valid_q[j] && (wsel_q[j] == src)) begin
                  hit = 1'b1;
                  if (LW'(j + 1) >= lat_q[j]) begin
                     fwd_sel[i*LW +: LW] = LW'(j + 1);
                  end else begin
                     stall = 1'b1;
                  end
               end
            end
         end
      end
   end

   // Issue gating and latency clamp into 1..STAGES.
   always_comb begin
      lat_clamped = issue_lat;
      if (issue_lat == '0) begin
         lat_clamped = LW'(1);
      end else if (issue_lat > LW'(STAGES)) begin
         lat_clamped = LW'(STAGES);
      end
      load_ok = issue_wen && (issue_wsel != '0) && !stall && !flush;
   end

   // Next-state: shift the table on advance; bubble into entry 1 unless a write issues.
   always_comb begin
      valid_d = valid_q;
      wsel_d  = wsel_q;
      lat_d   = lat_q;
      cnt_d   = cnt_q;
      if (advance) begin
         for (int j = int'(STAGES) - 1; j > 0; j--) begin
            valid_d[j] = valid_q[j-1];
            wsel_d[j]  = wsel_q[j-1];
            lat_d[j]   = lat_q[j-1];
         end
         valid_d[0] = load_ok;
         wsel_d[0]  = load_ok ? issue_wsel : '0;
         lat_d[0]   = load_ok ? lat_clamped : '0;
         if (stall && !flush && (cnt_q != '1)) begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // State registers with synchronous reset that drops every pending entry.
   always_ff @(posedge CLK) begin
      if (RST) begin
         valid_q <= '0;
         cnt_q   <= '0;
         for (int j = 0; j < int'(STAGES); j++) begin
            wsel_q[j] <= '0;
            lat_q[j]  <= '0;
         end
      end else begin
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
         for (int j = 0; j < int'(STAGES); j++) begin
            wsel_q[j] <= wsel_d[j];
            lat_q[j]  <= lat_d[j];
         end
      end
   end

   assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_forward_scoreboard.sv
// Directed self-checking bench for forward_scoreboard (STAGES=3, REGS=32, NSRC=2, CW=4).
module tb_forward_scoreboard;

   logic       CLK = 1'b0;
   logic       RST;
   logic       advance;
   logic       flush;
   logic       issue_wen;
   logic [4:0] issue_wsel;
   logic [1:0] issue_lat;
   logic [1:0] src_used;
   logic [9:0] src_sel;
   logic [3:0] fwd_sel;
   logic       stall;
   logic [3:0] stall_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   forward_scoreboard #(
      .STAGES (3),
      .REGS   (32),
      .NSRC   (2),
      .CW     (4)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .advance    (advance),
      .flush      (flush),
      .issue_wen  (issue_wen),
      .issue_wsel (issue_wsel),
      .issue_lat  (issue_lat),
      .src_used   (src_used),
      .src_sel    (src_sel),
      .fwd_sel    (fwd_sel),
      .stall      (stall),
      .stall_cnt  (stall_cnt)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_src(input logic [1:0] used, input logic [4:0] s1, input logic [4:0] s0);
      src_used = used;
      src_sel  = {s1, s0};
      #1;
   endtask

   task automatic issue(input logic [4:0] wsel, input logic [1:0] lat);
      issue_wen  = 1'b1;
      issue_wsel = wsel;
      issue_lat  = lat;
      src_used   = 2'b00;
      advance    = 1'b1;
      flush      = 1'b0;
      tick();
      issue_wen  = 1'b0;
   endtask

   task automatic drain();
      issue_wen = 1'b0;
      src_used  = 2'b00;
      flush     = 1'b0;
      advance   = 1'b1;
      repeat (3) tick();
   endtask

   task automatic test_reset();
      RST = 1'b1; advance = 1'b1; flush = 1'b1; issue_wen = 1'b1;
      issue_wsel = 5'd9; issue_lat = 2'd1;
      set_src(2'b11, 5'd9, 5'd9);
      repeat (2) tick();
      n_checks++;
      if (stall !== 1'b0) begin
         n_fail++; $display("FAIL reset_stall: got %b want 0", stall);
      end
      n_checks++;
      if (fwd_sel !== 4'h0) begin
         n_fail++; $display("FAIL reset_fwd: got %h want 0", fwd_sel);
      end
      n_checks++;
      if (stall_cnt !== 4'd0) begin
         n_fail++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt);
      end
      RST = 1'b0; advance = 1'b0; flush = 1'b0; issue_wen = 1'b0;
      set_src(2'b01, 5'd0, 5'd5);
      tick();
      n_checks++;
      if (fwd_sel !== 4'h0) begin
         n_fail++; $display("FAIL reset_hold_fwd: got %h want 0", fwd_sel);
      end
   endtask

   task automatic test_alu_chain();
      logic [1:0] exp_fwd [4];
      exp_fwd[0] = 2'd1; exp_fwd[1] = 2'd2; exp_fwd[2] = 2'd3; exp_fwd[3] = 2'd0;
      issue(5'd5, 2'd1);
      for (int c = 0; c < 4; c++) begin
         set_src(2'b01, 5'd0, 5'd5);
         n_checks++;
         if (fwd_sel[1:0] !== exp_fwd[c] || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_chain_%0d: got fwd=%0d stall=%b want fwd=%0d stall=0",
                     c, fwd_sel[1:0], stall, exp_fwd[c]);
         end
         advance = 1'b1;
         tick();
      end
   endtask

   task automatic test_load_use();
      drain();
      issue(5'd8, 2'd2);
      set_src(2'b10, 5'd8, 5'd0);
      n_checks++;
      if (stall !== 1'b1) begin
         n_fail++; $display("FAIL load_use_stall: got %b want 1", stall);
      end
      tick();
      n_checks++;
      if (stall !== 1'b0 || fwd_sel[3:2] !== 2'd2) begin
         n_fail++;
         $display("FAIL load_use_fwd: got stall=%b fwd1=%0d want stall=0 fwd1=2",
                  stall, fwd_sel[3:2]);
      end
      n_checks++;
      if (stall_cnt !== 4'd1) begin
         n_fail++; $display("FAIL load_use_cnt: got %0d want 1", stall_cnt);
      end
   endtask

   task automatic test_youngest_r0();
      drain();
      issue(5'd3, 2'd1);
      issue(5'd3, 2'd1);
      set_src(2'b01, 5'd0, 5'd3);
      n_checks++;
      if (fwd_sel[1:0] !== 2'd1) begin
         n_fail++; $display("FAIL youngest_wins: got %0d want 1", fwd_sel[1:0]);
      end
      issue(5'd0, 2'd1);
      set_src(2'b11, 5'd3, 5'd0);
      n_checks++;
      if (fwd_sel[1:0] !== 2'd0 || stall !== 1'b0) begin
         n_fail++;
         $display("FAIL r0_read: got fwd=%0d stall=%b want fwd=0 stall=0", fwd_sel[1:0], stall);
      end
      n_checks++;
      if (fwd_sel[3:2] !== 2'd2) begin
         n_fail++; $display("FAIL r3_after_r0: got %0d want 2", fwd_sel[3:2]);
      end
      // Latency 0 is treated as 1: forwardable right away.
      drain();
      issue(5'd7, 2'd0);
      set_src(2'b01, 5'd0, 5'd7);
      n_checks++;
      if (fwd_sel[1:0] !== 2'd1 || stall !== 1'b0) begin
         n_fail++;
         $display("FAIL lat0_clamp: got fwd=%0d stall=%b want fwd=1 stall=0", fwd_sel[1:0], stall);
      end
   endtask

   task automatic test_hold_flush();
      drain();
      issue(5'd8, 2'd3);
      set_src(2'b01, 5'd0, 5'd8);
      advance = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_checks++;
         if (stall !== 1'b1 || stall_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL hold_%0d: got stall=%b cnt=%0d want stall=1 cnt=1", c, stall, stall_cnt);
         end
      end
      advance = 1'b1; flush = 1'b1;
      issue_wen = 1'b1; issue_wsel = 5'd9; issue_lat = 2'd1;
      tick();
      flush = 1'b0; issue_wen = 1'b0; advance = 1'b0;
      set_src(2'b11, 5'd9, 5'd8);
      n_checks++;
      if (stall_cnt !== 4'd1) begin
         n_fail++; $display("FAIL flush_cnt: got %0d want 1", stall_cnt);
      end
      n_checks++;
      if (fwd_sel[3:2] !== 2'd0) begin
         n_fail++; $display("FAIL flush_bubble: got %0d want 0", fwd_sel[3:2]);
      end
      n_checks++;
      if (stall !== 1'b1) begin
         n_fail++; $display("FAIL flush_shift_stall: got %b want 1", stall);
      end
   endtask

   task automatic test_saturation_reset();
      drain();
      // Each round: one issue cycle, then two stalled advances (lat 3 at distances 1 and 2).
      for (int r = 0; r < 10; r++) begin
         issue(5'd10, 2'd3);
         set_src(2'b01, 5'd0, 5'd10);
         advance = 1'b1;
         repeat (2) tick();
         if (r == 2) begin
            n_checks++;
            if (stall_cnt !== 4'd7) begin
               n_fail++; $display("FAIL sat_partial: got %0d want 7", stall_cnt);
            end
         end
      end
      n_checks++;
      if (stall_cnt !== 4'd15) begin
         n_fail++; $display("FAIL sat_cnt: got %0d want 15", stall_cnt);
      end
      issue(5'd10, 2'd3);
      set_src(2'b11, 5'd10, 5'd10);
      RST = 1'b1; advance = 1'b1;
      tick();
      RST = 1'b0; advance = 1'b0;
      #1;
      n_checks++;
      if (stall_cnt !== 4'd0) begin
         n_fail++; $display("FAIL midreset_cnt: got %0d want 0", stall_cnt);
      end
      n_checks++;
      if (fwd_sel !== 4'h0 || stall !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_table: got fwd=%h stall=%b want fwd=0 stall=0", fwd_sel, stall);
      end
   endtask

   initial begin
      RST = 1'b1; advance = 1'b0; flush = 1'b0; issue_wen = 1'b0;
      issue_wsel = '0; issue_lat = '0; src_used = '0; src_sel = '0;
      test_reset();
      test_alu_chain();
      test_load_use();
      test_youngest_r0();
      test_hold_flush();
      test_saturation_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
